// File: rtl/mips_mem_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
// The package holds the FSM state encoding, the grant identities and the default bus widths.
package mips_mem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Identity of the requester that owns the current transaction.
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory signals of the arbiter, bundled into one interface.
// The slave modport is the arbiter's view; the master modport is the view of the requesters and the memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_adr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ack;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_adr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;

  logic [ADDR_W-1:0] m_adr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_read;
  logic              m_write;

  modport slave (
    input  i_req, i_adr, d_req, d_we, d_adr, d_wdata, m_rdata,
    output i_rdata, i_ack, d_rdata, d_ack, m_adr, m_wdata, m_read, m_write
  );

  modport master (
    output i_req, i_adr, d_req, d_we, d_adr, d_wdata, m_rdata,
    input  i_rdata, i_ack, d_rdata, d_ack, m_adr, m_wdata, m_read, m_write
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select. It is purely combinational and produces a one-hot grant.
// A lone request wins; on a tie, the requester that was not granted last wins.
module rr_arb2
  import mips_mem_pkg::*;
(
  input  logic       i_req_i,
  input  logic       d_req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o          // [0] = instruction, [1] = data
);

  always_comb begin
    gnt_o = 2'b00;
    if (i_req_i && d_req_i) begin
      gnt_o = (last_grant_i == GNT_D) ? 2'b01 : 2'b10;
    end else if (i_req_i) begin
      gnt_o = 2'b01;
    end else if (d_req_i) begin
      gnt_o = 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data access using IDLE -> ACCESS -> DONE.
// A request sampled in IDLE (cycle N) is accessed in N+1 and acked in N+2; other requests wait while busy.
module mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus,
  output logic         busy
);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              win_q, win_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [1:0]        gnt;

  rr_arb2 u_rr_arb2 (
    .i_req_i      (bus.i_req),
    .d_req_i      (bus.d_req),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_D;
      win_q        <= GNT_I;
      we_q         <= 1'b0;
      adr_q        <= '0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      win_q        <= win_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      wdata_q      <= wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    win_d        = win_q;
    we_d         = we_q;
    adr_d        = adr_q;
    wdata_d      = wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (gnt[1]) begin
          state_d      = ACCESS;
          last_grant_d = GNT_D;
          win_d        = GNT_D;
          we_d         = bus.d_we;
          adr_d        = bus.d_adr;
          wdata_d      = bus.d_wdata;
        end else if (gnt[0]) begin
          // Instruction fetch is always a read; wdata keeps its old value.
          state_d      = ACCESS;
          last_grant_d = GNT_I;
          win_d        = GNT_I;
          we_d         = 1'b0;
          adr_d        = bus.i_adr;
        end
      end
      ACCESS: begin
        state_d = DONE;
        if (!we_q) begin
          if (win_q == GNT_I) i_rdata_d = bus.m_rdata;
          else                d_rdata_d = bus.m_rdata;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode from the state register only, so an async reset kills them at once.
  assign bus.m_adr   = adr_q;
  assign bus.m_wdata = wdata_q;
  assign bus.m_read  = (state_q == ACCESS) && !we_q;
  assign bus.m_write = (state_q == ACCESS) && we_q;
  assign bus.i_ack   = (state_q == DONE) && (win_q == GNT_I);
  assign bus.d_ack   = (state_q == DONE) && (win_q == GNT_D);
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a combinational-read / clocked-write memory model.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  logic busy;
  int   total;
  int   bad;

  logic [31:0] mem [256];
  logic        pre_we;
  logic [7:0]  pre_adr;
  logic [31:0] pre_dat;
  int          wr_cnt;
  int          dack_cnt;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.m_rdata = mem[bus.m_adr[7:0]];

  always @(posedge clk) begin
    if (bus.m_write) mem[bus.m_adr[7:0]] <= bus.m_wdata;
    else if (pre_we) mem[pre_adr] <= pre_dat;
  end

  initial begin
    wr_cnt   = 0;
    dack_cnt = 0;
  end
  always @(posedge clk) begin
    if (bus.m_write) wr_cnt <= wr_cnt + 1;
    if (bus.d_ack)   dack_cnt <= dack_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_adr = a;
    pre_dat = d;
    pre_we  = 1'b1;
    tick();
    pre_we  = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (bus.m_read !== 1'b0 || bus.m_write !== 1'b0) begin bad++; $display("FAIL reset_strobes: got rd=%b wr=%b want 0 0", bus.m_read, bus.m_write); end
    total++; if (bus.i_ack !== 1'b0 || bus.d_ack !== 1'b0) begin bad++; $display("FAIL reset_acks: got i=%b d=%b want 0 0", bus.i_ack, bus.d_ack); end
    total++; if (bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got i=%h d=%h want 0 0", bus.i_rdata, bus.d_rdata); end
    total++; if (bus.m_adr !== 32'h0 || bus.m_wdata !== 32'h0) begin bad++; $display("FAIL reset_bus: got adr=%h wdata=%h want 0 0", bus.m_adr, bus.m_wdata); end
  endtask

  task automatic test_single_read();
    bus.i_adr = 32'h4;
    bus.i_req = 1'b1;
    tick();
    total++; if (bus.m_read !== 1'b1 || bus.m_write !== 1'b0) begin bad++; $display("FAIL rd_strobe: got rd=%b wr=%b want 1 0", bus.m_read, bus.m_write); end
    total++; if (bus.m_adr !== 32'h4) begin bad++; $display("FAIL rd_adr: got %h want 00000004", bus.m_adr); end
    total++; if (busy !== 1'b1 || bus.i_ack !== 1'b0) begin bad++; $display("FAIL rd_access: got busy=%b ack=%b want 1 0", busy, bus.i_ack); end
    tick();
    total++; if (bus.i_ack !== 1'b1 || bus.d_ack !== 1'b0) begin bad++; $display("FAIL rd_ack: got i=%b d=%b want 1 0", bus.i_ack, bus.d_ack); end
    total++; if (bus.i_rdata !== 32'h2002000A) begin bad++; $display("FAIL rd_data: got %h want 2002000a", bus.i_rdata); end
    total++; if (bus.m_read !== 1'b0) begin bad++; $display("FAIL rd_done_strobe: got %b want 0", bus.m_read); end
    bus.i_req = 1'b0;
    tick();
    total++; if (busy !== 1'b0 || bus.i_ack !== 1'b0) begin bad++; $display("FAIL rd_idle: got busy=%b ack=%b want 0 0", busy, bus.i_ack); end
    total++; if (bus.i_rdata !== 32'h2002000A || bus.m_adr !== 32'h4) begin bad++; $display("FAIL rd_hold: got rdata=%h adr=%h want 2002000a 00000004", bus.i_rdata, bus.m_adr); end
  endtask

  task automatic test_write_read();
    int w0;
    w0 = wr_cnt;
    bus.d_we = 1'b1; bus.d_adr = 32'h10; bus.d_wdata = 32'hDEADBEEF; bus.d_req = 1'b1;
    tick();
    total++; if (bus.m_write !== 1'b1 || bus.m_read !== 1'b0) begin bad++; $display("FAIL wr_strobe: got wr=%b rd=%b want 1 0", bus.m_write, bus.m_read); end
    total++; if (bus.m_wdata !== 32'hDEADBEEF || bus.m_adr !== 32'h10) begin bad++; $display("FAIL wr_bus: got wdata=%h adr=%h want deadbeef 00000010", bus.m_wdata, bus.m_adr); end
    tick();
    total++; if (bus.d_ack !== 1'b1 || bus.m_write !== 1'b0) begin bad++; $display("FAIL wr_ack: got ack=%b wr=%b want 1 0", bus.d_ack, bus.m_write); end
    total++; if (mem[8'h10] !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_mem: got %h want deadbeef", mem[8'h10]); end
    total++; if (bus.d_rdata !== 32'h0) begin bad++; $display("FAIL wr_rdata_keep: got %h want 0", bus.d_rdata); end
    bus.d_req = 1'b0;
    tick();
    bus.d_we = 1'b0; bus.d_req = 1'b1;
    tick();
    total++; if (bus.m_read !== 1'b1 || bus.m_write !== 1'b0) begin bad++; $display("FAIL wr_rd_strobe: got rd=%b wr=%b want 1 0", bus.m_read, bus.m_write); end
    tick();
    total++; if (bus.d_ack !== 1'b1 || bus.d_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rd_data: got ack=%b data=%h want 1 deadbeef", bus.d_ack, bus.d_rdata); end
    bus.d_req = 1'b0;
    tick();
    total++; if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL wr_pulses: got %0d want 1", wr_cnt - w0); end
  endtask

  task automatic test_contention();
    logic exp_i, exp_d;
    rst = 1'b0;
    bus.i_adr = 32'h4; bus.d_adr = 32'h10; bus.d_we = 1'b0;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    tick();
    rst = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp_i = (c == 2) || (c == 8);
      exp_d = (c == 5) || (c == 11);
      total++; if (bus.i_ack !== exp_i || bus.d_ack !== exp_d) begin bad++; $display("FAIL cont_ack c=%0d: got i=%b d=%b want %b %b", c, bus.i_ack, bus.d_ack, exp_i, exp_d); end
      if (c == 2) begin
        total++; if (bus.i_rdata !== 32'h2002000A) begin bad++; $display("FAIL cont_idata: got %h want 2002000a", bus.i_rdata); end
      end
      if (c == 5) begin
        total++; if (bus.d_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL cont_ddata: got %h want deadbeef", bus.d_rdata); end
      end
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cont_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic exp_d;
    bus.d_we = 1'b0; bus.d_adr = 32'h10; bus.d_req = 1'b1; bus.i_req = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      exp_d = (c == 2) || (c == 5) || (c == 8);
      total++; if (bus.d_ack !== exp_d || bus.i_ack !== 1'b0) begin bad++; $display("FAIL b2b_ack c=%0d: got d=%b i=%b want %b 0", c, bus.d_ack, bus.i_ack, exp_d); end
    end
    bus.d_req = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid_write();
    int a0;
    bus.d_we = 1'b1; bus.d_adr = 32'h20; bus.d_wdata = 32'hCAFEF00D; bus.d_req = 1'b1;
    tick();
    total++; if (bus.m_write !== 1'b1) begin bad++; $display("FAIL rst_wr_access: got %b want 1", bus.m_write); end
    a0 = dack_cnt;
    #2;
    rst = 1'b0;
    #1;
    total++; if (bus.m_write !== 1'b0 || bus.m_read !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_async: got wr=%b rd=%b busy=%b want 0 0 0", bus.m_write, bus.m_read, busy); end
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    tick();
    tick();
    total++; if (mem[8'h20] !== 32'h11111111) begin bad++; $display("FAIL rst_mem: got %h want 11111111", mem[8'h20]); end
    rst = 1'b1;
    tick();
    tick();
    total++; if (dack_cnt - a0 !== 0) begin bad++; $display("FAIL rst_no_ack: got %0d acks want 0", dack_cnt - a0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    bus.i_adr = 32'h4; bus.d_adr = 32'h10; bus.i_req = 1'b1; bus.d_req = 1'b1;
    tick();
    tick();
    total++; if (bus.i_ack !== 1'b1 || bus.d_ack !== 1'b0) begin bad++; $display("FAIL rst_tie: got i=%b d=%b want 1 0", bus.i_ack, bus.d_ack); end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b0;
    pre_we = 1'b0; pre_adr = 8'h0; pre_dat = 32'h0;
    bus.i_req = 1'b0; bus.i_adr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_adr = 32'h0; bus.d_wdata = 32'h0;
    tick();
    test_reset();
    preload(8'h04, 32'h2002000A);
    preload(8'h20, 32'h11111111);
    rst = 1'b1;
    tick();
    test_single_read();
    test_write_read();
    test_contention();
    test_back_to_back();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
